btn_event_scan: RTL and testbench

BTN_EVENT_SCAN -- requirements
Module: btn_event_scan

---
 rtl/btn_pkg.sv | 14 +
 rtl/btn_debounce.sv | 39 +++
 rtl/btn_event_scan.sv | 137 +++++++++++++
 tb/tb_btn_event_scan.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared defaults and width helper for the button event scanner.
package btn_pkg;

  localparam int unsigned DefNBtn       = 4;
  localparam int unsigned DefDbCycles   = 20000;
  localparam int unsigned DefLongCycles = 1000000;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int unsigned id_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser followed by a stable-count debouncer.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DefDbCycles
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_event_scan.sv
// Debounced button press scanner with round-robin event output and ready/valid handshake.
// Define BTN_LONG_PRESS_EN to add per-channel long-press events.
module btn_event_scan
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN       = DefNBtn,
  parameter int unsigned DB_CYCLES   = DefDbCycles,
  parameter int unsigned LONG_CYCLES = DefLongCycles
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N_BTN-1:0]       BTN,
  input  logic                   EVT_READY,
  output logic                   EVT_VALID,
  output logic [id_w(N_BTN)-1:0] EVT_ID,
  output logic                   EVT_LONG,
  output logic [N_BTN-1:0]       BTN_LEVEL,
  output logic                   PEND_OVF
);

  localparam int unsigned ID_W = id_w(N_BTN);
`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned NSLOT = 2 * N_BTN;
`else
  localparam int unsigned NSLOT = N_BTN;
`endif
  localparam int unsigned SLOT_W = id_w(NSLOT);

  logic [N_BTN-1:0]  level, level_prev_q, rise, pend_q;
  logic [NSLOT-1:0]  req, set_v, grant, req_d;
  logic [SLOT_W-1:0] ptr_q, win;
  logic [31:0]       idx;
  logic              found, load, ovf_d, valid_q, ovf_q;
  logic [ID_W-1:0]   id_q, win_id;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .btn    (BTN[i]),
      .level  (level[i])
    );
  end

  assign rise = level & ~level_prev_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [N_BTN-1:0]  lpend_q, lset;
  logic              win_long, long_q;

  // Hold counter saturates at LONG_CYCLES so the long event fires once per press.
  always_comb begin
    lset = '0;
    for (int i = 0; i < N_BTN; i++) begin
      lset[i] = level[i] && (hold_q[i] == HOLD_W'(LONG_CYCLES - 1));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
      lpend_q <= '0;
      long_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!level[i]) hold_q[i] <= '0;
        else if (hold_q[i] != HOLD_W'(LONG_CYCLES)) hold_q[i] <= hold_q[i] + HOLD_W'(1);
      end
      lpend_q <= req_d[NSLOT-1:N_BTN];
      if (load) long_q <= found && win_long;
    end
  end

  assign req      = {lpend_q, pend_q};
  assign set_v    = {lset, rise};
  assign win_long = (win >= SLOT_W'(N_BTN));
  assign win_id   = win_long ? ID_W'(win - SLOT_W'(N_BTN)) : ID_W'(win);
  assign EVT_LONG = long_q;
`else
  assign req      = pend_q;
  assign set_v    = rise;
  assign win_id   = ID_W'(win);
  assign EVT_LONG = 1'b0;
`endif

  // Round-robin search begins one slot after the last grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NSLOT; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NSLOT) idx = idx - NSLOT;
      if (!found && req[idx[SLOT_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SLOT_W-1:0];
      end
    end
    load = ~valid_q | EVT_READY;
    if (load && found) grant[win] = 1'b1;
    // A set on the granted bit wins, so the bit stays pending.
    req_d = (req & ~grant) | set_v;
    ovf_d = |(set_v & req & ~grant);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_prev_q <= '0;
      pend_q       <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      ovf_q        <= 1'b0;
      ptr_q        <= SLOT_W'(NSLOT - 1);
    end else begin
      level_prev_q <= level;
      pend_q       <= req_d[N_BTN-1:0];
      ovf_q        <= ovf_d;
      if (load) begin
        valid_q <= found;
        id_q    <= found ? win_id : '0;
        if (found) ptr_q <= win;
      end
    end
  end

  assign EVT_VALID = valid_q;
  assign EVT_ID    = id_q;
  assign BTN_LEVEL = level;
  assign PEND_OVF  = ovf_q;

endmodule

// File: tb/tb_btn_event_scan.sv
// Randomised and directed bench for btn_event_scan with a window-based reference model.
module tb_btn_event_scan;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int LONG = 16;
`ifdef BTN_LONG_PRESS_EN
  localparam int NS = 2 * N;
  localparam int LONG_EN = 1;
`else
  localparam int NS = N;
  localparam int LONG_EN = 0;
`endif

  typedef struct {
    int id;
    bit lng;
  } ev_t;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [N-1:0] BTN;
  logic         EVT_READY;
  logic         EVT_VALID;
  logic [1:0]   EVT_ID;
  logic         EVT_LONG;
  logic [N-1:0] BTN_LEVEL;
  logic         PEND_OVF;

  int n_chk  = 0;
  int n_fail = 0;

  btn_event_scan #(
    .N_BTN      (N),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .BTN      (BTN),
    .EVT_READY(EVT_READY),
    .EVT_VALID(EVT_VALID),
    .EVT_ID   (EVT_ID),
    .EVT_LONG (EVT_LONG),
    .BTN_LEVEL(BTN_LEVEL),
    .PEND_OVF (PEND_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once DB consecutive synchronised samples disagree with it.
  bit  samp [N][DB+2];
  bit  m_lvl [N];
  bit  m_prev [N];
  int  m_hold [N];
  bit  m_pend [NS];
  bit  m_valid, m_long, m_ovf;
  int  m_id, m_ptr;
  ev_t exp_q[$];

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < DB + 2; j++) samp[c][j] = 1'b0;
      m_lvl[c] = 1'b0; m_prev[c] = 1'b0; m_hold[c] = 0;
    end
    for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
    m_valid = 1'b0; m_long = 1'b0; m_ovf = 1'b0; m_id = 0; m_ptr = NS - 1;
    exp_q.delete();
  endtask

  task automatic m_step();
    bit  nl [N];
    bit  st [NS];
    bit  gr [NS];
    bit  found, diff, ld;
    int  win, s;
    ev_t e;
    for (int c = 0; c < N; c++) begin
      for (int j = DB + 1; j > 0; j--) samp[c][j] = samp[c][j-1];
      samp[c][0] = BTN[c];
      diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (samp[c][j] == m_lvl[c]) diff = 1'b0;
      nl[c] = diff ? !m_lvl[c] : m_lvl[c];
    end
    for (int i = 0; i < NS; i++) begin st[i] = 1'b0; gr[i] = 1'b0; end
    for (int c = 0; c < N; c++) begin
      st[c] = m_lvl[c] && !m_prev[c];
      if (LONG_EN != 0) st[(N + c) % NS] = m_lvl[c] && (m_hold[c] == LONG - 1);
    end
    ld = !m_valid || EVT_READY;
    found = 1'b0; win = 0;
    for (int k = 1; k <= NS; k++) begin
      s = (m_ptr + k) % NS;
      if (!found && m_pend[s]) begin found = 1'b1; win = s; end
    end
    if (ld) begin
      m_valid = found;
      m_id    = found ? win % N : 0;
      m_long  = found && (win >= N);
      if (found) begin
        gr[win] = 1'b1;
        m_ptr   = win;
        e.id = m_id; e.lng = m_long;
        exp_q.push_back(e);
      end
    end
    m_ovf = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (st[i] && m_pend[i] && !gr[i]) m_ovf = 1'b1;
      m_pend[i] = (m_pend[i] && !gr[i]) || st[i];
    end
    for (int c = 0; c < N; c++) begin
      m_hold[c] = m_lvl[c] ? ((m_hold[c] < LONG) ? m_hold[c] + 1 : LONG) : 0;
      m_prev[c] = m_lvl[c];
      m_lvl[c]  = nl[c];
    end
  endtask

  // Cycle checker: compares registered outputs, then advances the model one edge.
  always @(negedge CLK) begin
    logic [N-1:0] lv;
    for (int c = 0; c < N; c++) lv[c] = m_lvl[c];
    if (!RESET_N) begin
      chk("rst_valid", EVT_VALID, 0);
      chk("rst_id", EVT_ID, 0);
      chk("rst_long", EVT_LONG, 0);
      chk("rst_level", BTN_LEVEL, 0);
      chk("rst_ovf", PEND_OVF, 0);
      m_reset();
    end else begin
      chk("level", BTN_LEVEL, lv);
      chk("valid", EVT_VALID, m_valid);
      chk("id", EVT_ID, m_id);
      chk("long", EVT_LONG, m_long);
      chk("ovf", PEND_OVF, m_ovf);
      m_step();
    end
  end

  // Scoreboard monitor: pops on every accepted transfer.
  int  xfer [N][2];
  int  ovf_seen = 0;
  ev_t mon_e;

  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (PEND_OVF === 1'b1) ovf_seen++;
      if (EVT_VALID === 1'b1 && EVT_READY === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got id %0d long %0d required no event", EVT_ID, EVT_LONG);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_id", EVT_ID, mon_e.id);
          chk("sb_long", EVT_LONG, mon_e.lng);
        end
        xfer[EVT_ID][EVT_LONG]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr_xfer();
    for (int c = 0; c < N; c++) begin xfer[c][0] = 0; xfer[c][1] = 0; end
    ovf_seen = 0;
  endtask

  task automatic pulse_reset();
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
  endtask

  task automatic press(input int c, input int hi, input int lo);
    BTN[c] = 1'b1;
    tick(hi);
    BTN[c] = 1'b0;
    tick(lo);
  endtask

  initial begin
    int k;
    bit bad;
    RESET_N = 1'b0; BTN = '0; EVT_READY = 1'b1;
    clr_xfer();
    tick(3);
    RESET_N = 1'b1;
    tick(2);

    // Clean press latency.
    BTN[2] = 1'b1;
    k = 0;
    while (k <= 20) begin
      @(posedge CLK); k++; #1;
      if (EVT_VALID) break;
    end
    chk("s031_latency", k - 1, 7);
    chk("s031_id", EVT_ID, 2);
    chk("s031_long", EVT_LONG, 0);
    tick(1);
    chk("s031_one_cycle", EVT_VALID, 0);
    BTN[2] = 1'b0;
    tick(15);

    // Short glitch is rejected.
    BTN[1] = 1'b1;
    tick(3);
    BTN[1] = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (BTN_LEVEL[1] || EVT_VALID) bad = 1'b1;
    end
    chk("s032_glitch", bad, 0);

    // Simultaneous presses behind a stalled consumer.
    pulse_reset();
    EVT_READY = 1'b0;
    BTN = 4'b1011;
    bad = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (c == 10) BTN = '0;
      if (c >= 9 && !(EVT_VALID && EVT_ID == 2'd0)) bad = 1'b1;
    end
    chk("s033_stall_hold", bad, 0);
    EVT_READY = 1'b1;
    chk("s033_seq0", {EVT_VALID, EVT_ID}, 3'b100);
    tick(1);
    chk("s033_seq1", {EVT_VALID, EVT_ID}, 3'b101);
    tick(1);
    chk("s033_seq3", {EVT_VALID, EVT_ID}, 3'b111);
    tick(1);
    chk("s033_idle", {EVT_VALID, EVT_ID}, 3'b000);
    tick(10);

    // Repeated presses merge while the first event is stalled.
    clr_xfer();
    EVT_READY = 1'b0;
    press(3, 8, 8);
    press(3, 8, 8);
    press(3, 8, 8);
    EVT_READY = 1'b1;
    tick(10);
    chk("s034_ovf_pulses", ovf_seen, 1);
    chk("s034_id3_xfers", xfer[3][0], 2);

    // Held press, with optional long-press event.
    clr_xfer();
    press(1, 30, 20);
    chk("s035_press", xfer[1][0], 1);
    chk("s035_long", xfer[1][1], LONG_EN);

    // Reset while an event is presented and two more are pending.
    EVT_READY = 1'b0;
    BTN = 4'b0111;
    tick(12);
    chk("s036_presented", EVT_VALID, 1);
    BTN = '0;
    tick(1);
    RESET_N = 1'b0;
    #1;
    chk("s036_async_clr", {EVT_VALID, EVT_ID, EVT_LONG, BTN_LEVEL, PEND_OVF}, 0);
    tick(2);
    RESET_N = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (EVT_VALID) bad = 1'b1;
    end
    chk("s036_no_stale", bad, 0);

    // Button held across reset release yields a fresh press.
    clr_xfer();
    BTN[2] = 1'b1;
    tick(3);
    pulse_reset();
    EVT_READY = 1'b1;
    tick(14);
    BTN[2] = 1'b0;
    tick(10);
    chk("s026_held_reset", xfer[2][0], 1);

    // Random bounce and back-pressure.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) BTN[b] = ~BTN[b];
      EVT_READY = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    BTN = '0;
    EVT_READY = 1'b1;
    tick(60);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
